// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Receives a byte stream made of a 16-bit word count N (little-endian),
// then 4*N data bytes (each word least-significant byte first), then one
// XOR checksum byte covering the data bytes only. Each assembled word is
// written to the instruction memory in a single cycle. The CPU is held in
// reset until an image has loaded and its checksum matches.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader can accept a byte (decoded from state only)
//   reload     single-cycle pulse that restarts loading from any state
//   mem_we     instruction-memory write enable, one cycle per word
//   mem_addr   word address for the write
//   mem_wdata  word to write
//   cpu_hold   1 = keep CPU in reset
//   done       image loaded and checksum good
//   err        load failed (bad length or checksum)
//
// state | meaning
// LEN0  | waiting for low byte of word count
// LEN1  | waiting for high byte of word count
// DATA  | receiving data bytes, writing one word per 4 bytes
// CSUM  | waiting for checksum byte
// DONE  | image good, CPU released
// ERR   | image rejected, CPU held
module imem_loader #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);
    localparam logic [31:0]     DEPTH_U32 = 32'(DEPTH);

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     word_idx_q, word_idx_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [31:0]         asm_q, asm_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                ready;
    logic                accept;
    logic [15:0]         n_hdr;
    logic                len_bad;
    logic [31:0]         word_next;

    assign ready   = (state_q == LEN0) || (state_q == LEN1) ||
                     (state_q == DATA) || (state_q == CSUM);
    assign accept  = in_valid && ready;
    assign n_hdr   = {in_data, len_lo_q};
    assign len_bad = (n_hdr == 16'd0) || (32'(n_hdr) > DEPTH_U32);
    // New byte enters at the top so that after four bytes b0 sits in [7:0].
    assign word_next = {in_data, asm_q[31:8]};

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        csum_d      = csum_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;

        if (reload) begin
            // Overrides any byte handshaked in the same cycle.
            state_d    = LEN0;
            len_lo_d   = 8'd0;
            len_d      = '0;
            word_idx_d = '0;
            byte_cnt_d = 2'd0;
            csum_d     = 8'd0;
            asm_d      = 32'd0;
            cpu_hold_d = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                LEN0: begin
                    if (accept) begin
                        len_lo_d = in_data;
                        state_d  = LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        word_idx_d = '0;
                        byte_cnt_d = 2'd0;
                        csum_d     = 8'd0;
                        if (len_bad) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else begin
                            len_d   = n_hdr[ADDR_W:0];
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        asm_d      = word_next;
                        csum_d     = csum_q ^ in_data;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = word_idx_q[ADDR_W-1:0];
                            mem_wdata_d = word_next;
                            word_idx_d  = word_idx_q + IDX_ONE;
                            if (word_idx_q == len_q - IDX_ONE) begin
                                state_d = CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (in_data == csum_q) begin
                            state_d    = DONE;
                            done_d     = 1'b1;
                            cpu_hold_d = 1'b0;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                DONE: ;
                ERR:  ;
                default: begin
                    state_d    = ERR;
                    err_d      = 1'b1;
                    cpu_hold_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LEN0;
            len_lo_q    <= 8'd0;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= 2'd0;
            csum_q      <= 8'd0;
            asm_q       <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = ready;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int b2b    = 0;
    logic prev_we = 1'b0;
    int wr_base;

    logic [7:0] gs [11];

    imem_loader #(.ADDR_W(11), .DEPTH(2048)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) wr_cnt++;
        if (mem_we && prev_we) b2b++;
        prev_we = mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte after `gap` idle cycles; check write outputs #1 after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap, input logic exp_we,
                        input logic [10:0] exp_addr, input logic [31:0] exp_data);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mem_we_after_byte", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", mem_wdata, exp_data);
        end
    endtask

    task automatic good_stream(input int maxgap, input logic [7:0] last);
        for (int i = 0; i < 11; i++) begin
            logic [7:0] b;
            int g;
            b = (i == 10) ? last : gs[i];
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (i == 5)      send(b, g, 1'b1, 11'd0, 32'h12345678);
            else if (i == 9) send(b, g, 1'b1, 11'd1, 32'hDEADBEEF);
            else             send(b, g, 1'b0, 11'd0, 32'd0);
        end
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic chk_final_good(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_writes"}, 32'(wr_cnt - wr_base), 32'd2);
    endtask

    initial begin
        gs[0] = 8'h02; gs[1] = 8'h00;
        gs[2] = 8'h78; gs[3] = 8'h56; gs[4] = 8'h34; gs[5] = 8'h12;
        gs[6] = 8'hEF; gs[7] = 8'hBE; gs[8] = 8'hAD; gs[9] = 8'hDE;
        gs[10] = 8'h2A;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Good load
        wr_base = wr_cnt;
        good_stream(0, 8'h2A);
        chk_final_good("good");
        repeat (3) @(negedge clk);
        chk("good_stays_done", 32'(done), 32'd1);

        // Bad checksum
        do_reload();
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("reload_in_ready", 32'(in_ready), 32'd1);
        wr_base = wr_cnt;
        good_stream(0, 8'h2B);
        chk("badcs_err", 32'(err), 32'd1);
        chk("badcs_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_in_ready", 32'(in_ready), 32'd0);
        chk("badcs_writes", 32'(wr_cnt - wr_base), 32'd2);

        // Length zero
        do_reload();
        chk("reload_err", 32'(err), 32'd0);
        wr_base = wr_cnt;
        send(8'h00, 0, 1'b0, 11'd0, 32'd0);
        chk("len0_err_after_b1", 32'(err), 32'd0);
        send(8'h00, 0, 1'b0, 11'd0, 32'd0);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("len0_writes", 32'(wr_cnt - wr_base), 32'd0);

        // Length 2049
        do_reload();
        wr_base = wr_cnt;
        send(8'h01, 0, 1'b0, 11'd0, 32'd0);
        send(8'h08, 0, 1'b0, 11'd0, 32'd0);
        chk("len2049_err", 32'(err), 32'd1);
        chk("len2049_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (2) @(negedge clk);
        chk("len2049_writes", 32'(wr_cnt - wr_base), 32'd0);

        // Length 2048 proceeds to DATA
        do_reload();
        send(8'h00, 0, 1'b0, 11'd0, 32'd0);
        send(8'h08, 0, 1'b0, 11'd0, 32'd0);
        chk("len2048_err", 32'(err), 32'd0);
        chk("len2048_in_ready", 32'(in_ready), 32'd1);
        send(8'h04, 0, 1'b0, 11'd0, 32'd0);
        send(8'h03, 0, 1'b0, 11'd0, 32'd0);
        send(8'h02, 0, 1'b0, 11'd0, 32'd0);
        send(8'h01, 0, 1'b1, 11'd0, 32'h01020304);
        chk("len2048_still_loading", 32'(in_ready), 32'd1);

        // Throttled good load
        do_reload();
        wr_base = wr_cnt;
        good_stream(5, 8'h2A);
        chk_final_good("throttled");

        // Reload mid-load with a concurrent valid byte
        do_reload();
        for (int i = 0; i < 5; i++) send(gs[i], 0, 1'b0, 11'd0, 32'd0);
        send(gs[5], 0, 1'b1, 11'd0, 32'h12345678);
        @(negedge clk);
        in_data  = 8'hEF;
        in_valid = 1'b1;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reload   = 1'b0;
        chk("midreload_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midreload_in_ready", 32'(in_ready), 32'd1);
        chk("midreload_mem_we", 32'(mem_we), 32'd0);
        chk("midreload_done", 32'(done), 32'd0);
        wr_base = wr_cnt;
        good_stream(0, 8'h2A);
        chk_final_good("after_reload");

        // Reset mid-load
        do_reload();
        for (int i = 0; i < 5; i++) send(gs[i], 0, 1'b0, 11'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        wr_base = wr_cnt;
        good_stream(0, 8'h2A);
        chk_final_good("after_rst");

        @(negedge clk);
        chk("no_back_to_back_we", 32'(b2b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
